// File: rtl/freq_calc_if.sv
// Handshake bundle for freq_calc: count-pair input and frequency result output.
// master = upstream/consumer side, slave = the calculator.
interface freq_calc_if #(
    parameter int unsigned CW = 32,
    parameter int unsigned FW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] ca;
    logic [CW-1:0] cb;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_freq;
    logic          out_ovf;
    logic          out_div0;

    modport master (
        output in_valid, ca, cb, out_ready,
        input  in_ready, out_valid, out_freq, out_ovf, out_div0
    );

    modport slave (
        input  in_valid, ca, cb, out_ready,
        output in_ready, out_valid, out_freq, out_ovf, out_div0
    );
endinterface

// File: rtl/freq_calc.sv
// Converts a (ca, cb) gate-window count pair into f = cb * REF_HZ / ca as unsigned
// Q(FW-FRAC).FRAC fixed point, using a bit-serial restoring divider.
module freq_calc #(
    parameter int unsigned REF_HZ = 100_000_000,
    parameter int unsigned CW     = 32,
    parameter int unsigned FW     = 32,
    parameter int unsigned FRAC   = 8
) (
    input logic        clk,
    input logic        rst,
    freq_calc_if.slave bus
);
    localparam int unsigned RB   = $clog2(REF_HZ + 1);
    localparam int unsigned NW   = CW + RB + FRAC;
    localparam int unsigned CNTW = $clog2(NW + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q;
    logic [CW-1:0]   ca_q;
    logic [CW-1:0]   cb_q;
    logic [NW-1:0]   n_q;
    logic [CW:0]     r_q;
    logic [NW-1:0]   q_q;
    logic [CNTW-1:0] cnt_q;
    logic            out_valid_q;
    logic [FW-1:0]   out_freq_q;
    logic            out_ovf_q;
    logic            out_div0_q;

    logic [NW-1:0]   prod;
    logic [NW-1:0]   n_init;
    logic [CW:0]     r_shift;
    logic            r_ge;
    logic [CW:0]     r_next;
    logic [NW-1:0]   q_next;
    logic            ovf_next;
    logic            last_step;

    // One restoring-division step per cycle; R never exceeds 2*ca-1, so CW+1 bits suffice.
    always_comb begin
        prod      = NW'(cb_q) * NW'(REF_HZ);
        n_init    = prod << FRAC;
        r_shift   = {r_q[CW-1:0], n_q[NW-1]};
        r_ge      = r_shift >= {1'b0, ca_q};
        r_next    = r_ge ? (r_shift - {1'b0, ca_q}) : r_shift;
        q_next    = {q_q[NW-2:0], r_ge};
        ovf_next  = |q_next[NW-1:FW];
        last_step = cnt_q == CNTW'(NW - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ca_q        <= '0;
            cb_q        <= '0;
            n_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_freq_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_div0_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        ca_q       <= bus.ca;
                        cb_q       <= bus.cb;
                        out_ovf_q  <= 1'b0;
                        out_div0_q <= 1'b0;
                        if (bus.ca == '0) begin
                            out_div0_q  <= 1'b1;
                            out_freq_q  <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    n_q     <= n_init;
                    r_q     <= '0;
                    q_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= StDiv;
                end
                StDiv: begin
                    n_q   <= {n_q[NW-2:0], 1'b0};
                    r_q   <= r_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        out_valid_q <= 1'b1;
                        out_ovf_q   <= ovf_next;
                        out_freq_q  <= ovf_next ? '1 : q_next[FW-1:0];
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_freq  = out_freq_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_div0  = out_div0_q;
endmodule
